// File: rtl/matrix_mem_bank_if.sv
// Access bus for matrix_mem_bank: request, address/mode select, write data,
// and the registered read/status outputs.
interface matrix_mem_bank_if #(
  parameter int ELEM_W = 16,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DEPTH  = 8
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAT_W  = ELEM_W * ROWS * COLS;
  localparam int SEL_W  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

  logic              nEnable;
  logic              ReadWrite;
  logic [ADDR_W-1:0] address;
  logic [1:0]        mode;
  logic [SEL_W-1:0]  elem_sel;
  logic [MAT_W-1:0]  data_in;
  logic              clear_req;
  logic [MAT_W-1:0]  data_out;
  logic              data_valid;
  logic              busy;
  logic              err;

  modport master (
    output nEnable, ReadWrite, address, mode, elem_sel, data_in, clear_req,
    input  data_out, data_valid, busy, err
  );

  modport slave (
    input  nEnable, ReadWrite, address, mode, elem_sel, data_in, clear_req,
    output data_out, data_valid, busy, err
  );
endinterface

// File: rtl/matrix_mem_bank.sv
// Register-based store of DEPTH matrices with full/element/transposed access,
// a one-entry-per-cycle clear sweep, registered reads and error strobes.
module matrix_mem_bank #(
  parameter int ELEM_W = 16,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DEPTH  = 8
) (
  input logic              clk,
  input logic              nReset,
  matrix_mem_bank_if.slave bus
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAT_W  = ELEM_W * ROWS * COLS;

  typedef enum logic {IDLE, CLEAR} stateT;

  stateT             state;
  logic [MAT_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] cnt;
  logic [MAT_W-1:0]  dataOut;
  logic              dataValid;
  logic              busyReg;
  logic              errReg;
  logic              reqBad;
  logic [MAT_W-1:0]  entry;

  // Source (r,c) lands at (c,r) of a COLS x ROWS result; only used when square.
  function automatic logic [MAT_W-1:0] transpose(input logic [MAT_W-1:0] src);
    logic [MAT_W-1:0] dst;
    dst = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        dst[(c*ROWS + r)*ELEM_W +: ELEM_W] = src[(r*COLS + c)*ELEM_W +: ELEM_W];
    return dst;
  endfunction

  assign entry = mem[bus.address];

  always_comb begin
    reqBad = 1'b0;
    if (int'(bus.address) >= DEPTH) reqBad = 1'b1;
    case (bus.mode)
      2'b01:   if (int'(bus.elem_sel) >= ROWS*COLS) reqBad = 1'b1;
      2'b10:   if (ROWS != COLS) reqBad = 1'b1;
      2'b11:   reqBad = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      cnt       <= '0;
      dataOut   <= '0;
      dataValid <= 1'b0;
      busyReg   <= 1'b0;
      errReg    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      dataValid <= 1'b0;
      errReg    <= 1'b0;
      case (state)
        IDLE: begin
          // A clear request wins; any access presented alongside it is dropped.
          if (bus.clear_req) begin
            state   <= CLEAR;
            busyReg <= 1'b1;
            cnt     <= '0;
            errReg  <= ~bus.nEnable;
          end else if (!bus.nEnable) begin
            if (reqBad) begin
              errReg <= 1'b1;
            end else if (bus.ReadWrite) begin
              dataValid <= 1'b1;
              case (bus.mode)
                2'b01:   dataOut <= MAT_W'(entry[int'(bus.elem_sel)*ELEM_W +: ELEM_W]);
                2'b10:   dataOut <= transpose(entry);
                default: dataOut <= entry;
              endcase
            end else begin
              case (bus.mode)
                2'b01:   mem[bus.address][int'(bus.elem_sel)*ELEM_W +: ELEM_W] <= bus.data_in[ELEM_W-1:0];
                2'b10:   mem[bus.address] <= transpose(bus.data_in);
                default: mem[bus.address] <= bus.data_in;
              endcase
            end
          end
        end
        CLEAR: begin
          mem[cnt] <= '0;
          errReg   <= ~bus.nEnable | bus.clear_req;
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state   <= IDLE;
            busyReg <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_out   = dataOut;
  assign bus.data_valid = dataValid;
  assign bus.busy       = busyReg;
  assign bus.err        = errReg;
endmodule

// File: tb/tb_matrix_mem_bank.sv
// Directed plus randomized bench for matrix_mem_bank against an element-level
// reference model; a second small non-square instance covers rejected requests.
module tb_matrix_mem_bank;
  logic clk;
  logic nReset;
  int   totalCount;
  int   failCount;

  logic [15:0]  elems [8][16];
  logic [255:0] expOut;
  logic         expErr;
  logic         expValid;
  logic [127:0] expOut2;
  logic [127:0] din2;
  logic [255:0] tmp;
  int           busyCycles;

  matrix_mem_bank_if #(.ELEM_W(16), .ROWS(4), .COLS(4), .DEPTH(8)) bus ();
  matrix_mem_bank_if #(.ELEM_W(16), .ROWS(2), .COLS(4), .DEPTH(6)) bus2 ();

  matrix_mem_bank #(.ELEM_W(16), .ROWS(4), .COLS(4), .DEPTH(8)) dut (
    .clk(clk), .nReset(nReset), .bus(bus)
  );
  matrix_mem_bank #(.ELEM_W(16), .ROWS(2), .COLS(4), .DEPTH(6)) dutSmall (
    .clk(clk), .nReset(nReset), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    totalCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference view: element (r,c) of matrix m, optionally read transposed.
  function automatic logic [255:0] packMat(input int m, input bit trans);
    logic [255:0] v;
    v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        v[(r*4 + c)*16 +: 16] = trans ? elems[m][c*4 + r] : elems[m][r*4 + c];
    return v;
  endfunction

  task automatic zeroModel();
    for (int m = 0; m < 8; m++)
      for (int e = 0; e < 16; e++) elems[m][e] = '0;
  endtask

  task automatic applyStimulus(input bit rw, input int addr, input logic [1:0] md,
                               input int sel, input logic [255:0] din, input string tag);
    @(negedge clk);
    bus.nEnable   = 1'b0;
    bus.ReadWrite = rw;
    bus.address   = 3'(addr);
    bus.mode      = md;
    bus.elem_sel  = 4'(sel);
    bus.data_in   = din;
    bus.clear_req = 1'b0;
    @(posedge clk);
    #1;
    bus.nEnable = 1'b1;
    expErr   = 1'b0;
    expValid = 1'b0;
    if (md == 2'b11) begin
      expErr = 1'b1;
    end else if (rw) begin
      expValid = 1'b1;
      case (md)
        2'b01:   expOut = 256'(elems[addr][sel]);
        2'b10:   expOut = packMat(addr, 1'b1);
        default: expOut = packMat(addr, 1'b0);
      endcase
    end else begin
      case (md)
        2'b01: elems[addr][sel] = din[15:0];
        2'b10: begin
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) elems[addr][c*4 + r] = din[(r*4 + c)*16 +: 16];
        end
        default: for (int e = 0; e < 16; e++) elems[addr][e] = din[e*16 +: 16];
      endcase
    end
    checkOutput({tag, " err"}, 256'(bus.err), 256'(expErr));
    checkOutput({tag, " valid"}, 256'(bus.data_valid), 256'(expValid));
    checkOutput({tag, " data"}, bus.data_out, expOut);
  endtask

  task automatic smallStep(input bit rw, input int addr, input logic [1:0] md,
                           input int sel, input logic [127:0] din);
    @(negedge clk);
    bus2.nEnable   = 1'b0;
    bus2.ReadWrite = rw;
    bus2.address   = 3'(addr);
    bus2.mode      = md;
    bus2.elem_sel  = 3'(sel);
    bus2.data_in   = din;
    @(posedge clk);
    #1;
    bus2.nEnable = 1'b1;
  endtask

  task automatic midClockReset(input string tag);
    @(posedge clk);
    #3;
    nReset = 1'b0;
    #1;
    checkOutput({tag, " data"}, bus.data_out, '0);
    checkOutput({tag, " valid"}, 256'(bus.data_valid), '0);
    checkOutput({tag, " busy"}, 256'(bus.busy), '0);
    checkOutput({tag, " err"}, 256'(bus.err), '0);
    zeroModel();
    expOut = '0;
    @(negedge clk);
    nReset = 1'b1;
  endtask

  initial begin
    totalCount = 0;
    failCount  = 0;
    zeroModel();
    expOut = '0;
    nReset = 1'b0;
    bus.nEnable = 1'b1; bus.ReadWrite = 1'b0; bus.address = '0; bus.mode = '0;
    bus.elem_sel = '0; bus.data_in = '0; bus.clear_req = 1'b0;
    bus2.nEnable = 1'b1; bus2.ReadWrite = 1'b0; bus2.address = '0; bus2.mode = '0;
    bus2.elem_sel = '0; bus2.data_in = '0; bus2.clear_req = 1'b0;
    repeat (2) @(negedge clk);
    nReset = 1'b1;

    applyStimulus(0, 0, 2'b00, 0, 256'd42, "wr0");
    applyStimulus(0, 1, 2'b00, 0, 256'd56, "wr1");
    applyStimulus(0, 7, 2'b00, 0, 256'd203, "wr7");
    applyStimulus(1, 0, 2'b00, 0, '0, "rd0");
    applyStimulus(1, 1, 2'b00, 0, '0, "rd1");
    applyStimulus(1, 7, 2'b00, 0, '0, "rd7");
    checkOutput("rd7 const", bus.data_out, 256'd203);
    applyStimulus(0, 6, 2'b00, 0, rand256(), "b2b wr");
    applyStimulus(1, 6, 2'b00, 0, '0, "b2b rd");

    midClockReset("async reset");
    for (int a = 0; a < 8; a++) applyStimulus(1, a, 2'b00, 0, '0, "post-reset rd");

    applyStimulus(0, 2, 2'b00, 0, '0, "elem clr");
    applyStimulus(0, 2, 2'b01, 5, 256'hBEEF, "elem wr");
    applyStimulus(1, 2, 2'b00, 0, '0, "elem full rd");
    checkOutput("elem full const", bus.data_out, 256'hBEEF << 80);
    applyStimulus(1, 2, 2'b01, 5, '0, "elem rd");
    checkOutput("elem rd const", bus.data_out, 256'hBEEF);

    for (int i = 0; i < 16; i++) tmp[i*16 +: 16] = 16'(i);
    applyStimulus(0, 3, 2'b00, 0, tmp, "trans src");
    applyStimulus(1, 3, 2'b10, 0, '0, "trans rd");
    checkOutput("trans elem(0,1)", 256'(bus.data_out[16 +: 16]), 256'd4);
    applyStimulus(0, 4, 2'b10, 0, tmp, "trans wr");
    applyStimulus(1, 4, 2'b00, 0, '0, "trans wr rd");

    for (int i = 0; i < 60; i++)
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 7),
                    2'($urandom_range(0, 3)), $urandom_range(0, 15), rand256(), "rand");

    for (int a = 0; a < 8; a++) applyStimulus(0, a, 2'b00, 0, rand256(), "fill");
    @(negedge clk);
    bus.clear_req = 1'b1; bus.nEnable = 1'b0; bus.ReadWrite = 1'b1;
    bus.mode = 2'b00; bus.address = 3'd1;
    @(posedge clk);
    #1;
    bus.clear_req = 1'b0; bus.nEnable = 1'b1;
    checkOutput("clr+rd err", 256'(bus.err), 256'd1);
    checkOutput("clr+rd valid", 256'(bus.data_valid), '0);
    checkOutput("clr+rd data held", bus.data_out, expOut);
    busyCycles = bus.busy ? 1 : 0;
    for (int k = 0; k < 20 && bus.busy; k++) begin
      @(negedge clk);
      if (k == 1) begin bus.nEnable = 1'b0; bus.ReadWrite = 1'b1; bus.address = 3'd0; end
      if (k == 3) bus.clear_req = 1'b1;
      @(posedge clk);
      #1;
      if (k == 1 || k == 3) begin
        checkOutput("busy access err", 256'(bus.err), 256'd1);
        checkOutput("busy access valid", 256'(bus.data_valid), '0);
      end
      bus.nEnable = 1'b1;
      bus.clear_req = 1'b0;
      if (bus.busy) busyCycles++;
    end
    checkOutput("busy cycles", 256'(busyCycles), 256'd8);
    zeroModel();
    for (int a = 0; a < 8; a++) applyStimulus(1, a, 2'b00, 0, '0, "post-clear rd");

    for (int a = 0; a < 8; a++) applyStimulus(0, a, 2'b00, 0, rand256(), "refill");
    @(negedge clk);
    bus.clear_req = 1'b1;
    @(posedge clk);
    #1;
    bus.clear_req = 1'b0;
    checkOutput("clr alone err", 256'(bus.err), '0);
    checkOutput("clr alone busy", 256'(bus.busy), 256'd1);
    repeat (2) @(posedge clk);
    midClockReset("sweep reset");
    for (int a = 0; a < 8; a++) applyStimulus(1, a, 2'b00, 0, '0, "post-abort rd");

    tmp  = rand256();
    din2 = tmp[127:0];
    smallStep(0, 5, 2'b00, 0, din2);
    checkOutput("small wr err", 256'(bus2.err), '0);
    smallStep(1, 5, 2'b00, 0, '0);
    expOut2 = din2;
    checkOutput("small rd valid", 256'(bus2.data_valid), 256'd1);
    checkOutput("small rd data", 256'(bus2.data_out), 256'(expOut2));
    smallStep(1, 6, 2'b00, 0, '0);
    checkOutput("small addr6 err", 256'(bus2.err), 256'd1);
    checkOutput("small addr6 valid", 256'(bus2.data_valid), '0);
    checkOutput("small addr6 data", 256'(bus2.data_out), 256'(expOut2));
    smallStep(1, 7, 2'b00, 0, '0);
    checkOutput("small addr7 err", 256'(bus2.err), 256'd1);
    smallStep(1, 0, 2'b11, 0, '0);
    checkOutput("small mode11 err", 256'(bus2.err), 256'd1);
    checkOutput("small mode11 valid", 256'(bus2.data_valid), '0);
    smallStep(1, 5, 2'b10, 0, '0);
    checkOutput("small trans rd err", 256'(bus2.err), 256'd1);
    checkOutput("small trans rd data", 256'(bus2.data_out), 256'(expOut2));
    smallStep(0, 5, 2'b10, 0, ~din2);
    checkOutput("small trans wr err", 256'(bus2.err), 256'd1);
    smallStep(1, 5, 2'b01, 7, '0);
    checkOutput("small elem7 valid", 256'(bus2.data_valid), 256'd1);
    checkOutput("small elem7 data", 256'(bus2.data_out), 256'(din2[112 +: 16]));

    $display("%0d/%0d checks passed", totalCount - failCount, totalCount);
    $finish;
  end
endmodule
